// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin hold arbiter.
package arb_pkg;

    // Arbiter control states: nobody holds the resource, or someone does.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF  = 5;
    localparam int MAX_HOLD_DEF = 4;

    // Index width for n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// Round-robin picker: first set bit of mask, searching last+1, last+2, ...
// and wrapping modulo NUM_REQ. Purely combinational.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ_DEF)
) (
    input  logic [NUM_REQ-1:0] mask,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    idx,
    output logic [NUM_REQ-1:0] onehot
);

    // Walk the candidates in rotating order and keep the first hit.
    always_comb begin
        int          k;
        logic [ID_W-1:0] kk;
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        k      = 0;
        kk     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k  = (int'(last) + i) % NUM_REQ;
            kk = ID_W'(k);
            if (!found && mask[kk]) begin
                found      = 1'b1;
                idx        = kk;
                onehot[kk] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded hold. A holder keeps the grant while its
// request stays high; once it has held MAX_HOLD cycles and someone else is
// waiting, the grant moves on and preempt pulses for one cycle.
// Handshake: req is a level; gnt/gnt_id are registered and change only on
// clock edges (or drop asynchronously on reset). No request is latched.
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int ID_W     = id_width(NUM_REQ)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                busy,
    output logic                preempt,
    output logic                dbg_state,
    output logic [id_width(MAX_HOLD+1)-1:0] dbg_hold_cnt
);

    localparam int HC_W = id_width(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(MAX_HOLD);

    arb_state_t         state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    last_q;
    logic [HC_W-1:0]    hold_cnt_q;
    logic               preempt_q;

    // Candidate winner for the next edge.
    logic [NUM_REQ-1:0] cand_mask;
    logic               win_found_d;
    logic [ID_W-1:0]    win_id_d;
    logic [NUM_REQ-1:0] win_onehot_d;
    logic               holder_req;
    logic               limit_hit;

    // Masking out the current holder serves both cases with one picker: on a
    // release the holder's bit is already zero, and on preemption it must be
    // excluded. In IDLE gnt_q is zero so the full request vector is searched.
    // last_q equals the holder while in GRANT, so the search starts after it.
    assign cand_mask  = req & ~gnt_q;
    assign holder_req = |(req & gnt_q);
    assign limit_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HC_MAX);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .mask    (cand_mask),
        .last    (last_q),
        .found   (win_found_d),
        .idx     (win_id_d),
        .onehot  (win_onehot_d)
    );

    // Arbitration FSM with registered grant, pointer, hold counter and preempt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q    <= GRANT;
                        gnt_q      <= win_onehot_d;
                        gnt_id_q   <= win_id_d;
                        last_q     <= win_id_d;
                        hold_cnt_q <= HC_W'(1);
                    end
                end
                GRANT: begin
                    if (!holder_req) begin
                        // Release wins over a simultaneous hold-limit hit.
                        if (win_found_d) begin
                            gnt_q      <= win_onehot_d;
                            gnt_id_q   <= win_id_d;
                            last_q     <= win_id_d;
                            hold_cnt_q <= HC_W'(1);
                        end else begin
                            state_q    <= IDLE;
                            gnt_q      <= '0;
                            gnt_id_q   <= '0;
                            hold_cnt_q <= '0;
                        end
                    end else if (limit_hit && win_found_d) begin
                        gnt_q      <= win_onehot_d;
                        gnt_id_q   <= win_id_d;
                        last_q     <= win_id_d;
                        hold_cnt_q <= HC_W'(1);
                        preempt_q  <= 1'b1;
                    end else if ((MAX_HOLD != 0) && (hold_cnt_q != HC_MAX)) begin
                        hold_cnt_q <= hold_cnt_q + HC_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign gnt_id       = gnt_id_q;
    assign busy         = |gnt_q;
    assign preempt      = preempt_q;
    assign dbg_state    = (state_q == GRANT);
    assign dbg_hold_cnt = hold_cnt_q;

endmodule
